// File: rtl/capture_ctrl.sv
// Oscilloscope capture controller: decimated circular-buffer writes, pre-trigger arming,
// edge or auto trigger, post-trigger fill, then oldest-first readout of the frozen trace.
module capture_ctrl #(
    parameter int AW    = 9,
    parameter int DEC_W = 4,
    parameter int NT    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    smpl_vld,
    input  logic [NT-1:0]                           trig,
    input  logic [((NT > 1) ? $clog2(NT) : 1)-1:0]  trig_sel,
    input  logic                                    trig_edge,
    input  logic                                    run,
    input  logic                                    auto_roll,
    input  logic [DEC_W-1:0]                        decimator,
    input  logic [AW-1:0]                           trig_pos,
    input  logic                                    clr_cap_done,
    input  logic                                    dump_req,
    input  logic                                    dump_rdy,
    output logic                                    we,
    output logic [AW-1:0]                           waddr,
    output logic                                    rd_en,
    output logic [AW-1:0]                           raddr,
    output logic                                    armed,
    output logic                                    triggered,
    output logic                                    capture_done,
    output logic [AW-1:0]                           trace_end,
    output logic                                    dump_done
);

    localparam int DCW = (1 << DEC_W) - 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, DUMP} state_t;

    state_t          state;
    state_t          next_state;

    logic [DCW-1:0]  dec_cnt;
    logic [DCW-1:0]  dec_mask;
    logic [AW:0]     pre_cnt;
    logic [AW:0]     arm_level;
    logic [AW-1:0]   post_cnt;
    logic [AW:0]     rd_cnt;
    logic [NT-1:0]   trig_q;

    logic            keep;
    logic            in_capture;
    logic            post_full;
    logic            cap_keep;
    logic            sel_now;
    logic            sel_prev;
    logic            trig_hit;
    logic            read_go;
    logic            dump_last;
    logic            enter_done;
    logic            enter_dump;

    // Decimation: keep one strobe out of 2^decimator.
    always_comb begin
        dec_mask   = ~({DCW{1'b1}} << decimator);
        keep       = smpl_vld & (dec_cnt == dec_mask);
        in_capture = (state == PRE) || (state == ARMED) || (state == POST);
        post_full  = (post_cnt == trig_pos);
        cap_keep   = keep & ((state == PRE) || (state == ARMED) ||
                             ((state == POST) && !post_full));
        arm_level  = DEPTH - {1'b0, trig_pos};
    end

    // Selected trigger source and its edge against the previous cycle's value.
    always_comb begin
        sel_now  = trig[0];
        sel_prev = trig_q[0];
        for (int i = 0; i < NT; i++) begin
            if (int'(trig_sel) == i) begin
                sel_now  = trig[i];
                sel_prev = trig_q[i];
            end
        end
        trig_hit = trig_edge ? (sel_now & ~sel_prev) : (~sel_now & sel_prev);
    end

    always_comb begin
        read_go   = (state == DUMP) && dump_rdy && (rd_cnt != DEPTH);
        dump_last = (state == DUMP) && rd_en && (rd_cnt == DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (run && !capture_done) next_state = PRE;
            end
            PRE: begin
                if (!run)                        next_state = IDLE;
                else if (pre_cnt >= arm_level)   next_state = ARMED;
            end
            ARMED: begin
                if (!run)                        next_state = IDLE;
                else if (trig_hit || auto_roll)  next_state = POST;
            end
            POST: begin
                if (!run)                        next_state = IDLE;
                else if (post_full)              next_state = DONE;
            end
            DONE: begin
                if (clr_cap_done)                next_state = IDLE;
                else if (dump_req)               next_state = DUMP;
            end
            DUMP: begin
                if (dump_last)                   next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        armed      = (state == ARMED);
        triggered  = (state == POST) || (state == DONE) || (state == DUMP);
        enter_done = (state == POST) && (next_state == DONE);
        enter_dump = (state == DONE) && (next_state == DUMP);
    end

    // Write side: waddr is the address being written while we is high, then advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            waddr    <= '0;
            dec_cnt  <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            trig_q   <= '0;
        end else begin
            trig_q <= trig;
            we     <= cap_keep;
            if (we) begin
                waddr <= waddr + 1'b1;
            end

            if (state == IDLE) begin
                dec_cnt <= '0;
            end else if (in_capture && smpl_vld) begin
                dec_cnt <= keep ? '0 : dec_cnt + 1'b1;
            end

            if (state == IDLE) begin
                pre_cnt <= '0;
            end else if (cap_keep && ((state == PRE) || (state == ARMED)) &&
                         (pre_cnt != DEPTH)) begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (state == IDLE) begin
                post_cnt <= '0;
            end else if (cap_keep && (state == POST)) begin
                post_cnt <= post_cnt + 1'b1;
            end
        end
    end

    // Freeze: trace_end is the slot following the final write, i.e. the oldest sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_done <= 1'b0;
            trace_end    <= '0;
        end else begin
            if (enter_done) begin
                capture_done <= 1'b1;
                trace_end    <= we ? waddr + 1'b1 : waddr;
            end else if (clr_cap_done && (state != DUMP)) begin
                capture_done <= 1'b0;
            end
        end
    end

    // Read side mirrors the write side: raddr is valid with rd_en, then advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en     <= 1'b0;
            raddr     <= '0;
            rd_cnt    <= '0;
            dump_done <= 1'b0;
        end else begin
            rd_en     <= read_go;
            dump_done <= dump_last;
            if (enter_dump) begin
                raddr  <= trace_end;
                rd_cnt <= '0;
            end else begin
                if (rd_en) begin
                    raddr <= raddr + 1'b1;
                end
                if (read_go) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (AW=4): scenario tasks plus a write/read
// address scoreboard that pops expected addresses whenever we or rd_en is seen.
module tb_capture_ctrl;

    logic       clk;
    logic       rst;
    logic       smpl_vld;
    logic [1:0] trig;
    logic       trig_sel;
    logic       trig_edge;
    logic       run;
    logic       auto_roll;
    logic [3:0] decimator;
    logic [3:0] trig_pos;
    logic       clr_cap_done;
    logic       dump_req;
    logic       dump_rdy;
    logic       we;
    logic [3:0] waddr;
    logic       rd_en;
    logic [3:0] raddr;
    logic       armed;
    logic       triggered;
    logic       capture_done;
    logic [3:0] trace_end;
    logic       dump_done;

    int vec;
    int err;
    int cyc;
    int wr_seen;
    int rd_seen;
    int done_pulses;
    int done_cyc;
    int last_rd_cyc;

    logic [3:0] exp_wq[$];
    logic [3:0] exp_rq[$];
    logic [3:0] exp_w;
    logic [3:0] exp_r;
    logic [17:0] outs;

    capture_ctrl #(.AW(4), .DEC_W(4), .NT(2)) dut (
        .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .trig(trig), .trig_sel(trig_sel),
        .trig_edge(trig_edge), .run(run), .auto_roll(auto_roll), .decimator(decimator),
        .trig_pos(trig_pos), .clr_cap_done(clr_cap_done), .dump_req(dump_req),
        .dump_rdy(dump_rdy), .we(we), .waddr(waddr), .rd_en(rd_en), .raddr(raddr),
        .armed(armed), .triggered(triggered), .capture_done(capture_done),
        .trace_end(trace_end), .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        smpl_vld = 0; trig = 2'b00; trig_sel = 0; trig_edge = 1; run = 0; auto_roll = 0;
        decimator = 0; trig_pos = 0; clr_cap_done = 0; dump_req = 0; dump_rdy = 0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1;
        clear_inputs();
        exp_wq.delete();
        exp_rq.delete();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        @(negedge clk);
        outs = {we, waddr, rd_en, raddr, armed, triggered, capture_done, trace_end, dump_done};
        vec++;
        if (outs !== 18'd0) begin
            err++;
            $display("[TB] FAIL reset_outputs: got %b, want all zero", outs);
        end
        tick();
        run = 1; smpl_vld = 1; trig = 2'b11;
        @(negedge clk);
        vec++;
        if ({we, armed, waddr} !== 6'd0) begin
            err++;
            $display("[TB] FAIL reset_hold: got we=%b armed=%b waddr=%0d, want 0 0 0", we, armed, waddr);
        end
        tick();
        clear_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_trigger();
        logic exp_a;
        logic exp_t;
        do_reset();
        trig_pos = 4; decimator = 0; trig_sel = 0; trig_edge = 1;
        tick();
        run = 1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            smpl_vld = 1;
            if (k == 20) trig = 2'b01;
            exp_wq.push_back(4'(k - 1));
            @(negedge clk);
            exp_a = (k >= 14) && (k <= 20);
            exp_t = (k >= 21);
            vec++;
            if (armed !== exp_a) begin
                err++;
                $display("[TB] FAIL trig_armed strobe %0d: got %b, want %b", k, armed, exp_a);
            end
            vec++;
            if (triggered !== exp_t) begin
                err++;
                $display("[TB] FAIL trig_triggered strobe %0d: got %b, want %b", k, triggered, exp_t);
            end
        end
        tick();
        smpl_vld = 0;
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b0) begin
            err++;
            $display("[TB] FAIL trig_done_early: got %b, want 0", capture_done);
        end
        tick();
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b1) begin
            err++;
            $display("[TB] FAIL trig_done: got %b, want 1", capture_done);
        end
        vec++;
        if (trace_end !== 4'd8) begin
            err++;
            $display("[TB] FAIL trig_trace_end: got %0d, want 8", trace_end);
        end
        vec++;
        if (exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL trig_writes: %0d expected writes missing, want 0", exp_wq.size());
        end
    endtask

    task automatic test_decimation();
        int wr_base;
        do_reset();
        decimator = 2; trig_pos = 4;
        wr_base = wr_seen;
        tick();
        run = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            smpl_vld = 1;
            if (k % 4 == 0) exp_wq.push_back(4'(k / 4 - 1));
        end
        tick();
        smpl_vld = 0; run = 0;
        tick();
        tick();
        @(negedge clk);
        vec++;
        if (wr_seen - wr_base != 10) begin
            err++;
            $display("[TB] FAIL dec_we_count: got %0d, want 10", wr_seen - wr_base);
        end
        vec++;
        if (exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL dec_writes: %0d expected writes missing, want 0", exp_wq.size());
        end
        vec++;
        if (armed !== 1'b0) begin
            err++;
            $display("[TB] FAIL dec_armed: got %b, want 0", armed);
        end
    endtask

    task automatic test_auto_roll();
        int  wr_base;
        bit  saw_armed;
        bit  found;
        do_reset();
        decimator = 0; trig_pos = 0; auto_roll = 1;
        wr_base = wr_seen; saw_armed = 0; found = 0;
        tick();
        run = 1;
        for (int s = 0; s < 16; s++) begin
            tick();
            smpl_vld = 1;
            exp_wq.push_back(4'(s));
            @(negedge clk);
            vec++;
            if (triggered !== 1'b0) begin
                err++;
                $display("[TB] FAIL roll_early strobe %0d: got triggered=%b, want 0", s, triggered);
            end
            tick();
            smpl_vld = 0;
            tick();
        end
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (armed === 1'b1) saw_armed = 1;
            if (capture_done === 1'b1) found = 1;
            else tick();
        end
        vec++;
        if (!found) begin
            err++;
            $display("[TB] FAIL roll_done_timeout: got capture_done=%b, want 1 within 12 cycles", capture_done);
        end
        vec++;
        if (!saw_armed) begin
            err++;
            $display("[TB] FAIL roll_armed: got no armed cycle, want one");
        end
        vec++;
        if (triggered !== 1'b1) begin
            err++;
            $display("[TB] FAIL roll_triggered: got %b, want 1", triggered);
        end
        vec++;
        if (wr_seen - wr_base != 16 || exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL roll_writes: got %0d writes (%0d pending), want 16 (0)",
                     wr_seen - wr_base, exp_wq.size());
        end
        vec++;
        if (trace_end !== 4'd0) begin
            err++;
            $display("[TB] FAIL roll_trace_end: got %0d, want 0", trace_end);
        end
    endtask

    task automatic test_falling_edge();
        logic exp_a;
        logic exp_t;
        do_reset();
        trig = 2'b10; trig_sel = 1; trig_edge = 0; trig_pos = 5; decimator = 0;
        tick();
        run = 1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            smpl_vld = 1;
            trig[0] = (k % 2 == 1);
            if (k == 5)  trig[1] = 1'b0;
            if (k == 8)  trig[1] = 1'b1;
            if (k == 16) trig[1] = 1'b0;
            exp_wq.push_back(4'(k - 1));
            @(negedge clk);
            exp_a = (k >= 13) && (k <= 16);
            exp_t = (k >= 17);
            vec++;
            if (armed !== exp_a || triggered !== exp_t) begin
                err++;
                $display("[TB] FAIL fall_status strobe %0d: got armed=%b trig=%b, want %b %b",
                         k, armed, triggered, exp_a, exp_t);
            end
        end
        tick();
        smpl_vld = 0;
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b0) begin
            err++;
            $display("[TB] FAIL fall_done_early: got %b, want 0", capture_done);
        end
        tick();
        run = 0;
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b1 || trace_end !== 4'd5) begin
            err++;
            $display("[TB] FAIL fall_done: got done=%b trace_end=%0d, want 1 5", capture_done, trace_end);
        end
        vec++;
        if (exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL fall_writes: %0d expected writes missing, want 0", exp_wq.size());
        end
    endtask

    task automatic test_dump();
        int rd_base;
        int dp_base;
        bit done_seen;
        rd_base = rd_seen; dp_base = done_pulses; done_seen = 0;
        tick();
        dump_req = 1; dump_rdy = 1;
        for (int i = 0; i < 16; i++) exp_rq.push_back(4'(5 + i));
        for (int i = 1; i <= 100 && !done_seen; i++) begin
            tick();
            dump_req = 0;
            dump_rdy = (i % 2 == 1);
            clr_cap_done = (i < 8);
            @(negedge clk);
            vec++;
            if (capture_done !== 1'b1 || triggered !== 1'b1) begin
                err++;
                $display("[TB] FAIL dump_hold cycle %0d: got done=%b trig=%b, want 1 1",
                         i, capture_done, triggered);
            end
            if (dump_done === 1'b1) done_seen = 1;
        end
        vec++;
        if (!done_seen) begin
            err++;
            $display("[TB] FAIL dump_timeout: got no dump_done in 100 cycles, want one");
        end
        tick();
        dump_rdy = 0; clr_cap_done = 0;
        tick();
        tick();
        @(negedge clk);
        vec++;
        if (rd_seen - rd_base != 16 || exp_rq.size() != 0) begin
            err++;
            $display("[TB] FAIL dump_reads: got %0d reads (%0d pending), want 16 (0)",
                     rd_seen - rd_base, exp_rq.size());
        end
        vec++;
        if (done_pulses - dp_base != 1) begin
            err++;
            $display("[TB] FAIL dump_done_width: got %0d cycles high, want 1", done_pulses - dp_base);
        end
        vec++;
        if (done_cyc != last_rd_cyc + 1) begin
            err++;
            $display("[TB] FAIL dump_done_timing: got cycle %0d, want %0d", done_cyc, last_rd_cyc + 1);
        end
        vec++;
        if (capture_done !== 1'b1) begin
            err++;
            $display("[TB] FAIL dump_after_done: got %b, want 1", capture_done);
        end
        tick();
        clr_cap_done = 1; dump_req = 1;
        tick();
        clr_cap_done = 0; dump_req = 0;
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b0 || triggered !== 1'b0) begin
            err++;
            $display("[TB] FAIL clr_priority: got done=%b trig=%b, want 0 0", capture_done, triggered);
        end
        tick();
        tick();
        tick();
        @(negedge clk);
        vec++;
        if (rd_seen - rd_base != 16) begin
            err++;
            $display("[TB] FAIL clr_no_read: got %0d reads, want 16", rd_seen - rd_base);
        end
    endtask

    task automatic test_reset_in_post();
        do_reset();
        trig_pos = 8; auto_roll = 1; decimator = 0;
        tick();
        run = 1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            smpl_vld = 1;
            if (k <= 10) exp_wq.push_back(4'(k - 1));
            @(negedge clk);
            vec++;
            if (armed !== (k == 10) || triggered !== (k >= 11)) begin
                err++;
                $display("[TB] FAIL rpost_status strobe %0d: got armed=%b trig=%b, want %b %b",
                         k, armed, triggered, (k == 10), (k >= 11));
            end
        end
        tick();
        rst = 1; smpl_vld = 0;
        @(negedge clk);
        outs = {we, waddr, rd_en, raddr, armed, triggered, capture_done, trace_end, dump_done};
        vec++;
        if (outs !== 18'd0) begin
            err++;
            $display("[TB] FAIL rpost_outputs: got %b, want all zero", outs);
        end
        vec++;
        if (exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL rpost_writes: %0d expected writes missing, want 0", exp_wq.size());
        end
        tick();
        rst = 0;
    endtask

    task automatic test_run_low();
        do_reset();
        trig_pos = 8; decimator = 0;
        tick();
        run = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            smpl_vld = 1;
            exp_wq.push_back(4'(k - 1));
        end
        tick();
        smpl_vld = 0; run = 0;
        @(negedge clk);
        vec++;
        if (armed !== 1'b1) begin
            err++;
            $display("[TB] FAIL rlow_armed: got %b, want 1", armed);
        end
        tick();
        @(negedge clk);
        vec++;
        if (armed !== 1'b0 || capture_done !== 1'b0 || triggered !== 1'b0) begin
            err++;
            $display("[TB] FAIL rlow_idle: got armed=%b done=%b trig=%b, want 0 0 0",
                     armed, capture_done, triggered);
        end
        tick();
        tick();
        @(negedge clk);
        vec++;
        if (capture_done !== 1'b0 || exp_wq.size() != 0) begin
            err++;
            $display("[TB] FAIL rlow_final: got done=%b pending=%0d, want 0 0",
                     capture_done, exp_wq.size());
        end
    endtask

    initial begin
        vec = 0; err = 0; cyc = 0; wr_seen = 0; rd_seen = 0;
        done_pulses = 0; done_cyc = -1; last_rd_cyc = -1;
        rst = 1;
        clear_inputs();

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (we === 1'b1) begin
                    wr_seen++;
                    vec++;
                    if (exp_wq.size() == 0) begin
                        err++;
                        $display("[TB] FAIL write_addr: got write at %0d, want no write", waddr);
                    end else begin
                        exp_w = exp_wq.pop_front();
                        if (waddr !== exp_w) begin
                            err++;
                            $display("[TB] FAIL write_addr: got %0d, want %0d", waddr, exp_w);
                        end
                    end
                end
                if (rd_en === 1'b1) begin
                    rd_seen++;
                    last_rd_cyc = cyc;
                    vec++;
                    if (exp_rq.size() == 0) begin
                        err++;
                        $display("[TB] FAIL read_addr: got read at %0d, want no read", raddr);
                    end else begin
                        exp_r = exp_rq.pop_front();
                        if (raddr !== exp_r) begin
                            err++;
                            $display("[TB] FAIL read_addr: got %0d, want %0d", raddr, exp_r);
                        end
                    end
                end
                if (dump_done === 1'b1) begin
                    done_pulses++;
                    done_cyc = cyc;
                end
            end
        join_none

        test_reset();
        test_trigger();
        test_decimation();
        test_auto_roll();
        test_falling_edge();
        test_dump();
        test_reset_in_post();
        test_run_low();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
